// File: rtl/asmd_pkg.sv
// Shared definitions for the shift/add multiplier: the state encoding and the
// magnitude helper used at operand capture.
package asmd_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam int MAG_MAX_W = 64;

   // Callers zero-extend into MAG_MAX_W and cast the result back to their width.
   // The low bits of the negation are the narrow two's-complement negation.
   function automatic logic [MAG_MAX_W-1:0] mag_f(input logic [MAG_MAX_W-1:0] val_i,
                                                  input logic                 negate_i);
      return negate_i ? (~val_i + MAG_MAX_W'(1)) : val_i;
   endfunction

endpackage

// File: rtl/asmd_gen_datapath.sv
// Operand, accumulator and product registers for the shift/add multiplier,
// plus the status flags the controller steers on.
module asmd_gen_datapath
   import asmd_pkg::*;
#(
   parameter int WORD_LENGTH = 8,
   parameter int SIGNED_EN   = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load_i,
   input  logic                     step_i,
   input  logic                     fix_i,
   input  logic                     signed_mode_i,
   input  logic [WORD_LENGTH-1:0]   word0_i,
   input  logic [WORD_LENGTH-1:0]   word1_i,
   output logic [2*WORD_LENGTH-1:0] product_o,
   output logic                     zero_o,
   output logic                     mplier_one_o
);

   localparam int N  = WORD_LENGTH;
   localparam int W2 = 2 * WORD_LENGTH;

   logic          signed_eff;
   logic [N-1:0]  mag0, mag1;
   logic          m0;

   logic [W2-1:0] mcand_q, mcand_d;
   logic [N-1:0]  mplier_q, mplier_d;
   logic [W2-1:0] acc_q, acc_d;
   logic [W2-1:0] product_q, product_d;
   logic          neg_q, neg_d;

   assign signed_eff   = (SIGNED_EN != 0) && signed_mode_i;
   assign mag0         = N'(mag_f(MAG_MAX_W'(word0_i), signed_eff && word0_i[N-1]));
   assign mag1         = N'(mag_f(MAG_MAX_W'(word1_i), signed_eff && word1_i[N-1]));
   assign zero_o       = (word0_i == '0) || (word1_i == '0);
   assign mplier_one_o = (mplier_q == N'(1));
   assign m0           = mplier_q[0];
   assign product_o    = product_q;

   always_comb begin
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      product_d = product_q;
      neg_d     = neg_q;
      if (load_i) begin
         mcand_d  = W2'(mag0);
         mplier_d = mag1;
         acc_d    = '0;
         neg_d    = signed_eff && (word0_i[N-1] ^ word1_i[N-1]);
         if (zero_o) begin
            product_d = '0;
         end
      end else if (step_i) begin
         if (m0) begin
            acc_d = acc_q + mcand_q;
         end
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
      end else if (fix_i) begin
         product_d = neg_q ? (~acc_q + W2'(1)) : acc_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         product_q <= '0;
         neg_q     <= 1'b0;
      end else begin
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         product_q <= product_d;
         neg_q     <= neg_d;
      end
   end

endmodule

// File: rtl/asmd_multiplier_gen.sv
// Sequential shift/add multiplier with signed mode, early termination on the
// multiplier MSB and a ready/done handshake.
//
// state  | meaning
// S_IDLE | ready; accept start and capture operand magnitudes
// S_RUN  | one add/shift per cycle until the multiplier reaches 1
// S_FIX  | apply the result sign and load the product register
// S_DONE | one-cycle done pulse
module asmd_multiplier_gen
   import asmd_pkg::*;
#(
   parameter int WORD_LENGTH = 8,
   parameter int SIGNED_EN   = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     signed_mode,
   input  logic [WORD_LENGTH-1:0]   word0,
   input  logic [WORD_LENGTH-1:0]   word1,
   output logic [2*WORD_LENGTH-1:0] product,
   output logic                     ready,
   output logic                     done
);

   state_t state_q, state_d;
   logic   ready_q, done_q;
   logic   load, step, fix;
   logic   zero, mplier_one;

   asmd_gen_datapath #(
      .WORD_LENGTH (WORD_LENGTH),
      .SIGNED_EN   (SIGNED_EN)
   ) u_datapath (
      .clk           (clk),
      .rst           (reset),
      .load_i        (load),
      .step_i        (step),
      .fix_i         (fix),
      .signed_mode_i (signed_mode),
      .word0_i       (word0),
      .word1_i       (word1),
      .product_o     (product),
      .zero_o        (zero),
      .mplier_one_o  (mplier_one)
   );

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      fix     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_d = zero ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            step = 1'b1;
            if (mplier_one) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            fix     = 1'b1;
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ready/done are registered from the next state so they align with state_q.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= (state_d == S_IDLE);
         done_q  <= (state_d == S_DONE);
      end
   end

   assign ready = ready_q;
   assign done  = done_q;

endmodule

// File: tb/tb_asmd_multiplier_gen.sv
// Directed bench for asmd_multiplier_gen (N=8): products, done latency,
// handshake, ignored start while busy, and asynchronous reset mid-run.
module tb_asmd_multiplier_gen;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        signed_mode = 1'b0;
   logic [7:0]  word0 = 8'h00;
   logic [7:0]  word1 = 8'h00;
   logic [15:0] product;
   logic        ready;
   logic        done;

   int pass_cnt = 0;
   int fail_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   asmd_multiplier_gen #(
      .WORD_LENGTH (8),
      .SIGNED_EN   (1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .signed_mode (signed_mode),
      .word0       (word0),
      .word1       (word1),
      .product     (product),
      .ready       (ready),
      .done        (done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Edge 1 is the accept edge; exp_edges is the edge after which done is high.
   task automatic run_op(input string tag, input logic sm, input logic [7:0] a,
                         input logic [7:0] b, input logic [15:0] exp_p,
                         input int exp_edges, input bit disturb);
      int n;
      @(negedge clk);
      word0       = a;
      word1       = b;
      signed_mode = sm;
      start       = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n = 1;
      check({tag, " ready_low"}, 32'(ready), 32'd0);
      while (!done && n < 30) begin
         @(posedge clk);
         #1;
         n++;
         if (disturb && n == 2) begin
            word0       = 8'hAA;
            word1       = 8'h00;
            signed_mode = ~sm;
            start       = 1'b1;
         end
         if (disturb && n == 3) start = 1'b0;
      end
      check({tag, " done_edge"}, 32'(n), 32'(exp_edges));
      check({tag, " product"}, 32'(product), 32'(exp_p));
      @(posedge clk);
      #1;
      check({tag, " ready_after"}, 32'(ready), 32'd1);
      check({tag, " done_pulse"}, 32'(done), 32'd0);
      check({tag, " product_hold"}, 32'(product), 32'(exp_p));
   endtask

   initial begin
      #1 reset = 1'b1;
      #1;
      check("reset product", 32'(product), 32'd0);
      check("reset ready", 32'(ready), 32'd1);
      check("reset done", 32'(done), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      run_op("u3x5",    1'b0, 8'h03, 8'h05, 16'h000F, 5,  1'b0);
      run_op("s-3x5",   1'b1, 8'hFD, 8'h05, 16'hFFF1, 5,  1'b0);
      run_op("s80x80",  1'b1, 8'h80, 8'h80, 16'h4000, 10, 1'b0);
      run_op("uFFxFF",  1'b0, 8'hFF, 8'hFF, 16'hFE01, 10, 1'b0);
      run_op("uFFx02",  1'b0, 8'hFF, 8'h02, 16'h01FE, 4,  1'b0);
      run_op("sFFx02",  1'b1, 8'hFF, 8'h02, 16'hFFFE, 4,  1'b0);
      run_op("zero",    1'b0, 8'h00, 8'h7F, 16'h0000, 1,  1'b0);
      run_op("s7Fx81",  1'b1, 8'h7F, 8'h81, 16'hC0FF, 9,  1'b0);
      run_op("disturb", 1'b0, 8'h07, 8'h21, 16'h00E7, 8,  1'b0 | 1'b1);

      // Abort a long operation mid-run; product still holds 00E7 beforehand.
      @(negedge clk);
      word0       = 8'hFF;
      word1       = 8'hFF;
      signed_mode = 1'b0;
      start       = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      check("midreset product", 32'(product), 32'd0);
      check("midreset ready", 32'(ready), 32'd1);
      check("midreset done", 32'(done), 32'd0);
      #2 reset = 1'b0;

      run_op("post_reset", 1'b0, 8'h03, 8'h05, 16'h000F, 5, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
